mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1; 1 selects round-robin arbitration, 0 selects fixed LSU priority.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ifu_req_valid  input  1  instruction fetch read request.
REQ-005 SHALL have port ifu_req_ready  output  1  IFU request accepted this cycle when high with ifu_req_valid.
REQ-006 SHALL have port ifu_req_addr  input  64  fetch byte address.
REQ-007 SHALL have ports ifu_resp_valid output 1, ifu_resp_ready input 1, ifu_resp_data output 64  fetch response handshake and data.
REQ-008 SHALL have ports lsu_req_valid input 1, lsu_req_ready output 1  LSU request handshake.
REQ-009 SHALL have ports lsu_req_write input 1, lsu_req_addr input 64, lsu_req_wdata input 64, lsu_req_size input 2  LSU op (1=store), address, store data, log2 byte count.
REQ-010 SHALL have ports lsu_resp_valid output 1, lsu_resp_ready input 1, lsu_resp_data output 64  LSU response handshake and load data.
REQ-011 SHALL have ports mem_rd_en output 1, mem_rd_addr output 64, mem_rd_data input 64  shared memory read port; mem_rd_data is valid combinationally in the cycle mem_rd_en is high.
REQ-012 SHALL have ports mem_we_en output 1, mem_we_addr output 64, mem_we_data output 64, mem_we_mask output 8  shared memory write port.

Function
REQ-013 SHALL implement states IDLE, ACCESS and RESP.
REQ-014 SHALL assert ifu_req_ready and lsu_req_ready only in IDLE, and never both in the same cycle.
REQ-015 In IDLE with exactly one valid request, SHALL grant that requester.
REQ-016 On a simultaneous request with RR_EN=1, SHALL grant the requester not granted most recently; with RR_EN=0, SHALL grant LSU.
REQ-017 On grant, SHALL latch the winner's address, write flag, wdata and size, record the winner, and move to ACCESS.
REQ-018 IFU requests SHALL always be treated as 8-byte reads.
REQ-019 In ACCESS, for a read, SHALL drive mem_rd_en=1 and mem_rd_addr=latched address, and capture mem_rd_data into the response register.
REQ-020 In ACCESS, for a write, SHALL drive mem_we_en=1, mem_we_addr/mem_we_data from the latches, and mem_we_mask 0x01/0x03/0x0F/0xFF for size 0/1/2/3; the response data register SHALL be 0.
REQ-021 ACCESS SHALL last exactly one cycle, then move to RESP.
REQ-022 Outside ACCESS, SHALL hold mem_rd_en=0, mem_we_en=0, all mem addresses/data=0 and mem_we_mask=0.
REQ-023 In RESP, SHALL assert resp_valid only toward the granted requester, with resp_data = the captured register; the other requester's resp_data SHALL be 0.
REQ-024 SHALL hold RESP, with valid and data stable, until the matching resp_ready is high; it SHALL then return to IDLE the following cycle.
REQ-025 Accept-to-resp_valid latency SHALL be 2 cycles: accept at edge t, ACCESS in cycle t+1, resp_valid in cycle t+2; back-to-back throughput SHALL be one transaction per 3 cycles.
REQ-026 Request inputs changing while not ready SHALL have no effect; a request that loses arbitration SHALL remain pending, with no latching.
REQ-027 The round-robin pointer SHALL update only on grant.

Reset
REQ-028 While reset=0, SHALL force IDLE, all valid/ready/enable outputs to 0, all data/addr/mask outputs to 0, and last-granted to LSU, so IFU wins the first conflict.
REQ-029 Reset asserted in ACCESS or RESP SHALL abort the transaction without any memory write after reset assertion and without a response after release.
REQ-030 After reset release, ready SHALL reflect pending requests in the first cycle.

Verification
REQ-031 IFU read addr 0x80000000, mem_rd_data=0x00000013_00000093, resp_ready=1 -> mem_rd_en high one cycle at t+1; ifu_resp_valid at t+2 with data 0x0000001300000093.
REQ-032 LSU store addr 0x80001000, wdata 0x1122334455667788, size 1 -> one cycle with mem_we_en=1, mask 0x03, data 0x1122334455667788; lsu_resp_valid at t+2 with data 0.
REQ-033 Both request every cycle, RR_EN=1 -> grants IFU, LSU, IFU, LSU; with RR_EN=0 -> LSU always granted, IFU starved.
REQ-034 LSU load, lsu_resp_ready held 0 for 5 cycles -> lsu_resp_valid and data stable for 5 cycles; no further mem access and no ready until handshake.
REQ-035 Reset pulsed during ACCESS of a store -> mem_we_en drops immediately; no response after release; next IFU request served normally.
REQ-036 Simultaneous first requests after reset -> IFU granted first.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: routes IFU fetches and LSU loads/stores onto one shared
// single-cycle memory, one transaction at a time (IDLE -> ACCESS -> RESP).
module mem_arbiter #(
    parameter int unsigned RR_EN = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_req_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [63:0] ifu_resp_data,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_req_write,
    input  logic [63:0] lsu_req_addr,
    input  logic [63:0] lsu_req_wdata,
    input  logic [1:0]  lsu_req_size,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [63:0] lsu_resp_data,
    output logic        mem_rd_en,
    output logic [63:0] mem_rd_addr,
    input  logic [63:0] mem_rd_data,
    output logic        mem_we_en,
    output logic [63:0] mem_we_addr,
    output logic [63:0] mem_we_data,
    output logic [7:0]  mem_we_mask
);

    localparam int unsigned XLEN   = 64;
    localparam int unsigned MASK_W = 8;
    localparam int unsigned SIZE_W = 2;
    localparam bit          RR     = (RR_EN != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic grant_ifu;
    logic grant_lsu;
    logic resp_hs;
    logic last_lsu_q;
    logic owner_lsu_q;
    logic write_q;
    logic [XLEN-1:0] rdata;

    function automatic logic [MASK_W-1:0] size_mask(input logic [SIZE_W-1:0] size);
        logic [MASK_W-1:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_ifu || grant_lsu) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    if (resp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Arbitration and handshake decode; ready is only ever offered to the winner
    always_comb begin
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        if (reset && state_q == IDLE) begin
            if (ifu_req_valid && lsu_req_valid) begin
                if (RR && last_lsu_q) begin
                    grant_ifu = 1'b1;
                end else begin
                    grant_lsu = 1'b1;
                end
            end else begin
                grant_ifu = ifu_req_valid;
                grant_lsu = lsu_req_valid;
            end
        end
        ifu_req_ready = grant_ifu;
        lsu_req_ready = grant_lsu;
        resp_hs       = (state_q == RESP) && (owner_lsu_q ? lsu_resp_ready : ifu_resp_ready);
        rdata         = write_q ? '0 : mem_rd_data;
    end

    // Datapath: the memory port registers double as the request latches and
    // are only non-zero during the single ACCESS cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_lsu_q     <= 1'b1;
            owner_lsu_q    <= 1'b0;
            write_q        <= 1'b0;
            mem_rd_en      <= 1'b0;
            mem_rd_addr    <= '0;
            mem_we_en      <= 1'b0;
            mem_we_addr    <= '0;
            mem_we_data    <= '0;
            mem_we_mask    <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_resp_data  <= '0;
            lsu_resp_valid <= 1'b0;
            lsu_resp_data  <= '0;
        end else begin
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            mem_we_en   <= 1'b0;
            mem_we_addr <= '0;
            mem_we_data <= '0;
            mem_we_mask <= '0;
            if (grant_ifu || grant_lsu) begin
                owner_lsu_q <= grant_lsu;
                last_lsu_q  <= grant_lsu;
                write_q     <= grant_lsu && lsu_req_write;
                if (grant_lsu && lsu_req_write) begin
                    mem_we_en   <= 1'b1;
                    mem_we_addr <= lsu_req_addr;
                    mem_we_data <= lsu_req_wdata;
                    mem_we_mask <= size_mask(lsu_req_size);
                end else begin
                    mem_rd_en   <= 1'b1;
                    mem_rd_addr <= grant_lsu ? lsu_req_addr : ifu_req_addr;
                end
            end
            if (state_q == ACCESS) begin
                if (owner_lsu_q) begin
                    lsu_resp_valid <= 1'b1;
                    lsu_resp_data  <= rdata;
                end else begin
                    ifu_resp_valid <= 1'b1;
                    ifu_resp_data  <= rdata;
                end
            end
            if (resp_hs) begin
                ifu_resp_valid <= 1'b0;
                ifu_resp_data  <= '0;
                lsu_resp_valid <= 1'b0;
                lsu_resp_data  <= '0;
            end
        end
    end

endmodule
